// File: rtl/givens_pe_scheduler_pkg.sv
// Shared types, scheme codes and the fixed step table for the Givens PE scheduler.
package givens_pe_scheduler_pkg;

   localparam int unsigned PE_LAT_DEF = 8;
   localparam int unsigned STEP_W_DEF = 3;
   localparam int unsigned SCHEME_W   = 2;

   localparam logic [SCHEME_W-1:0] COMPLEX_2_REAL = 2'd0;
   localparam logic [SCHEME_W-1:0] COMPLEX_ROTATE = 2'd1;
   localparam logic [SCHEME_W-1:0] REAL_NULLIFIED = 2'd2;
   localparam logic [SCHEME_W-1:0] RELATED_ROTATE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_A = 3'd1,
      ST_WAIT_A  = 3'd2,
      ST_ISSUE_B = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   typedef struct packed {
      logic [SCHEME_W-1:0] scheme0;
      logic [SCHEME_W-1:0] scheme1;
      logic                row;
      logic                col;
      logic                fb;
      logic                swap;
   } step_fields_t;

   typedef struct packed {
      logic row;
      logic col;
      logic swap;
   } step_loc_t;

   // Fixed sweep order: four file-fed steps, then four feedback steps.
   function automatic step_fields_t step_decode(input logic [STEP_W_DEF-1:0] step);
      step_fields_t f;
      f = '0;
      case (step)
         3'd0: f = '{COMPLEX_2_REAL, COMPLEX_ROTATE, 1'b0, 1'b0, 1'b0, 1'b0};
         3'd1: f = '{COMPLEX_ROTATE, COMPLEX_ROTATE, 1'b0, 1'b1, 1'b0, 1'b0};
         3'd2: f = '{COMPLEX_2_REAL, COMPLEX_ROTATE, 1'b1, 1'b0, 1'b0, 1'b0};
         3'd3: f = '{COMPLEX_ROTATE, COMPLEX_ROTATE, 1'b1, 1'b1, 1'b0, 1'b0};
         3'd4: f = '{REAL_NULLIFIED, RELATED_ROTATE, 1'b0, 1'b0, 1'b1, 1'b0};
         3'd5: f = '{RELATED_ROTATE, RELATED_ROTATE, 1'b0, 1'b1, 1'b1, 1'b0};
         3'd6: f = '{REAL_NULLIFIED, RELATED_ROTATE, 1'b1, 1'b0, 1'b1, 1'b1};
         3'd7: f = '{RELATED_ROTATE, RELATED_ROTATE, 1'b1, 1'b1, 1'b1, 1'b1};
         default: f = '0;
      endcase
      return f;
   endfunction

   function automatic step_loc_t step_loc(input logic [STEP_W_DEF-1:0] step);
      step_fields_t f;
      f = step_decode(step);
      return '{row: f.row, col: f.col, swap: f.swap};
   endfunction

endpackage

// File: rtl/givens_pe_scheduler_if.sv
// Control bundle between the scheduler and the bidiagonalization top level.
interface givens_pe_scheduler_if;
   import givens_pe_scheduler_pkg::*;

   logic                  start_i;
   logic                  busy_o;
   logic                  done_o;
   logic [1:0]            pe0_valid_o;
   logic [1:0]            pe1_valid_o;
   logic [SCHEME_W-1:0]   pe0_scheme_o;
   logic [SCHEME_W-1:0]   pe1_scheme_o;
   logic                  rd_row_o;
   logic                  rd_col_o;
   logic                  rd_fb_o;
   logic                  rd_swap_o;
   logic [STEP_W_DEF-1:0] step_o;
   logic                  wb_valid_o;
   logic                  wb_row_o;
   logic                  wb_col_o;
   logic                  wb_swap_o;

   modport master (
      input  start_i,
      output busy_o, done_o, pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
             rd_row_o, rd_col_o, rd_fb_o, rd_swap_o, step_o,
             wb_valid_o, wb_row_o, wb_col_o, wb_swap_o
   );

   modport slave (
      output start_i,
      input  busy_o, done_o, pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
             rd_row_o, rd_col_o, rd_fb_o, rd_swap_o, step_o,
             wb_valid_o, wb_row_o, wb_col_o, wb_swap_o
   );

endinterface

// File: rtl/givens_pe_scheduler_pe_tag_pipe.sv
// Delay line carrying {valid, step} tags alongside the PE pipeline.
module givens_pe_scheduler_pe_tag_pipe #(
   parameter int unsigned DEPTH = 7,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/givens_pe_scheduler.sv
// Issue/writeback sequencer for the two-PE Givens datapath; the top level keeps
// the data registers and muxes, this block owns every timing decision.
module givens_pe_scheduler
   import givens_pe_scheduler_pkg::*;
#(
   parameter int unsigned PE_LAT = PE_LAT_DEF,
   parameter int unsigned STEP_W = STEP_W_DEF
) (
   input logic                  clk,
   input logic                  rst,
   givens_pe_scheduler_if.master bus
);

   localparam int unsigned CYC_W = $clog2(2 * PE_LAT + 6);
   localparam int unsigned TAG_W = STEP_W + 1;

   state_e             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [STEP_W-1:0]  iss_q, iss_d;
   logic               issue_q, issue_d;
   logic [STEP_W-1:0]  step_q, step_d;
   step_fields_t       fld_q, fld_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [TAG_W-1:0]   tag_q;
   logic               wb_valid_q, wb_valid_d;
   step_loc_t          wb_loc_q, wb_loc_d;

   // cyc_q is the pass-relative cycle number of the current cycle (0 when idle).
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      iss_d   = iss_q;
      issue_d = 1'b0;
      step_d  = '0;
      fld_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            cyc_d = '0;
            iss_d = '0;
            if (bus.start_i) begin
               state_d = ST_ISSUE_A;
               cyc_d   = CYC_W'(1);
            end
         end
         ST_ISSUE_A: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(4)) state_d = (PE_LAT == 4) ? ST_ISSUE_B : ST_WAIT_A;
         end
         ST_WAIT_A: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(PE_LAT)) state_d = ST_ISSUE_B;
         end
         ST_ISSUE_B: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(PE_LAT + 4)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(2 * PE_LAT + 4)) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cyc_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = '0;
         end
      endcase
      // Issue fields are decoded one cycle early so they present as registers.
      if (state_d == ST_ISSUE_A || state_d == ST_ISSUE_B) begin
         issue_d = 1'b1;
         step_d  = iss_q;
         iss_d   = iss_q + STEP_W'(1);
         fld_d   = step_decode(STEP_W_DEF'(iss_q));
      end
      busy_d = (state_d == ST_ISSUE_A) || (state_d == ST_WAIT_A) ||
               (state_d == ST_ISSUE_B) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cyc_q   <= '0;
         iss_q   <= '0;
         issue_q <= 1'b0;
         step_q  <= '0;
         fld_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         iss_q   <= iss_d;
         issue_q <= issue_d;
         step_q  <= step_d;
         fld_q   <= fld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // PE_LAT-1 tag stages plus the writeback register give exactly PE_LAT cycles.
   givens_pe_scheduler_pe_tag_pipe #(
      .DEPTH (PE_LAT - 1),
      .WIDTH (TAG_W)
   ) u_tag_pipe (
      .clk (clk),
      .rst (rst),
      .d_i ({issue_q, step_q}),
      .q_o (tag_q)
   );

   always_comb begin
      wb_valid_d = tag_q[TAG_W-1];
      wb_loc_d   = '0;
      if (wb_valid_d) wb_loc_d = step_loc(STEP_W_DEF'(tag_q[STEP_W-1:0]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_loc_q   <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_loc_q   <= wb_loc_d;
      end
   end

   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.pe0_valid_o  = {2{issue_q}};
   assign bus.pe1_valid_o  = {2{issue_q}};
   assign bus.pe0_scheme_o = fld_q.scheme0;
   assign bus.pe1_scheme_o = fld_q.scheme1;
   assign bus.rd_row_o     = fld_q.row;
   assign bus.rd_col_o     = fld_q.col;
   assign bus.rd_fb_o      = fld_q.fb;
   assign bus.rd_swap_o    = fld_q.swap;
   assign bus.step_o       = STEP_W_DEF'(step_q);
   assign bus.wb_valid_o   = wb_valid_q;
   assign bus.wb_row_o     = wb_loc_q.row;
   assign bus.wb_col_o     = wb_loc_q.col;
   assign bus.wb_swap_o    = wb_loc_q.swap;

endmodule

// File: tb/tb_givens_pe_scheduler.sv
// Directed bench: three scheduler instances (PE_LAT 8, 4, 15) checked cycle by cycle.
module tb_givens_pe_scheduler;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   givens_pe_scheduler_if if8 ();
   givens_pe_scheduler_if if4 ();
   givens_pe_scheduler_if if15 ();

   givens_pe_scheduler #(.PE_LAT(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
   givens_pe_scheduler #(.PE_LAT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
   givens_pe_scheduler #(.PE_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(if15));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pe0_valid, pe1_valid, scheme0, scheme1, rd_row, rd_col, rd_fb, rd_swap, step,
   //  wb_valid, wb_row, wb_col, wb_swap, busy, done}
   logic [20:0] obs [3];
   assign obs[0] = {if8.pe0_valid_o, if8.pe1_valid_o, if8.pe0_scheme_o, if8.pe1_scheme_o,
                    if8.rd_row_o, if8.rd_col_o, if8.rd_fb_o, if8.rd_swap_o, if8.step_o,
                    if8.wb_valid_o, if8.wb_row_o, if8.wb_col_o, if8.wb_swap_o,
                    if8.busy_o, if8.done_o};
   assign obs[1] = {if4.pe0_valid_o, if4.pe1_valid_o, if4.pe0_scheme_o, if4.pe1_scheme_o,
                    if4.rd_row_o, if4.rd_col_o, if4.rd_fb_o, if4.rd_swap_o, if4.step_o,
                    if4.wb_valid_o, if4.wb_row_o, if4.wb_col_o, if4.wb_swap_o,
                    if4.busy_o, if4.done_o};
   assign obs[2] = {if15.pe0_valid_o, if15.pe1_valid_o, if15.pe0_scheme_o, if15.pe1_scheme_o,
                    if15.rd_row_o, if15.rd_col_o, if15.rd_fb_o, if15.rd_swap_o, if15.step_o,
                    if15.wb_valid_o, if15.wb_row_o, if15.wb_col_o, if15.wb_swap_o,
                    if15.busy_o, if15.done_o};

   // Hand-written step table: {scheme0, scheme1, row, col, fb, swap}.
   function automatic logic [7:0] tbl(input int s);
      case (s)
         0: return 8'b00_01_0_0_0_0;
         1: return 8'b01_01_0_1_0_0;
         2: return 8'b00_01_1_0_0_0;
         3: return 8'b01_01_1_1_0_0;
         4: return 8'b10_11_0_0_1_0;
         5: return 8'b11_11_0_1_1_0;
         6: return 8'b10_11_1_0_1_1;
         7: return 8'b11_11_1_1_1_1;
         default: return 8'h00;
      endcase
   endfunction

   // Expected output vector in pass-relative cycle c for latency l.
   function automatic logic [20:0] exp_all(input int l, input int c);
      logic [14:0] iss;
      logic [3:0]  wb;
      logic [1:0]  ctl;
      logic [7:0]  t;
      int s;
      iss = '0;
      wb  = '0;
      s   = -1;
      if (c >= 1 && c <= 4) s = c - 1;
      else if (c >= l + 1 && c <= l + 4) s = c - l + 3;
      if (s >= 0) begin
         t   = tbl(s);
         iss = {4'b1111, t, 3'(s)};
      end
      s = -1;
      if (c >= l + 1 && c <= l + 4) s = c - l - 1;
      else if (c >= 2 * l + 1 && c <= 2 * l + 4) s = c - 2 * l + 3;
      if (s >= 0) begin
         t  = tbl(s);
         wb = {1'b1, t[3], t[2], t[0]};
      end
      ctl = {(c >= 1 && c <= 2 * l + 4), (c == 2 * l + 5)};
      return {iss, wb, ctl};
   endfunction

   task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic set_start(input logic v);
      if8.start_i  = v;
      if4.start_i  = v;
      if15.start_i = v;
   endtask

   int lat [3] = '{8, 4, 15};

   initial begin
      logic [20:0] e;
      int j;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      set_start(1'b0);
      @(negedge clk);
      @(negedge clk);

      // Reset state
      for (int d = 0; d < 3; d++) chk($sformatf("reset_d%0d", lat[d]), obs[d], 21'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Single pass on all three latencies, start pulsed for one cycle
      set_start(1'b1);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) set_start(1'b0);
         for (int d = 0; d < 3; d++)
            chk($sformatf("pass_L%0d_c%0d", lat[d], c), obs[d], exp_all(lat[d], c));
      end

      // start held for 30 cycles: a new pass starts only from an IDLE cycle
      set_start(1'b1);
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 30) set_start(1'b0);
         for (int d = 0; d < 3; d++) begin
            j = (c - 1) / (2 * lat[d] + 6);
            if (j * (2 * lat[d] + 6) <= 29) e = exp_all(lat[d], c - j * (2 * lat[d] + 6));
            else e = 21'd0;
            chk($sformatf("hold_L%0d_c%0d", lat[d], c), obs[d], e);
         end
      end
      repeat (4) @(negedge clk);

      // Reset mid-pass at cycle 10
      set_start(1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) set_start(1'b0);
         for (int d = 0; d < 3; d++)
            chk($sformatf("pre_rst_L%0d_c%0d", lat[d], c), obs[d], exp_all(lat[d], c));
      end
      rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("rst_async_L%0d", lat[d]), obs[d], 21'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 3; d++)
            chk($sformatf("post_rst_L%0d_c%0d", lat[d], c), obs[d], 21'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/givens_pe_scheduler.md
Name: givens_pe_scheduler

Overview:
- Sequencer for the two-PE Givens-rotation datapath used in the 4x4 complex-channel bidiagonalization.
- Drives PE valid/scheme controls, selects which 2x2 sub-block of the matrix register file feeds the PEs, and marks whether operands come from the file or from PE outputs (feedback) and whether rows are swapped.
- Tracks in-flight PE operations so writebacks to the matrix file arrive at the correct cycle with the correct destination.
- Replaces hard-coded phase decoding in the top level. The top level keeps the data registers and muxes; this block owns all timing.

Parameters:
PE_LAT, 8, PE pipeline latency in cycles from issue to output; legal range 4..15
STEP_W, 3, step index width (8 steps)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  begin one bidiagonalization pass; sampled in IDLE only
busy_o  out  1  pass in progress
done_o  out  1  one-cycle pulse when pass complete
pe0_valid_o  out  2  PE0 operand-valid pair (2'b11 on issue, else 2'b00)
pe1_valid_o  out  2  PE1 operand-valid pair
pe0_scheme_o  out  2  PE0 scheme: 0 COMPLEX_2_REAL, 1 COMPLEX_ROTATE, 2 REAL_NULLIFIED, 3 RELATED_ROTATE
pe1_scheme_o  out  2  PE1 scheme
rd_row_o  out  1  operand row pair: 0 = rows 0/1, 1 = rows 2/3
rd_col_o  out  1  operand column pair: 0 = PE0 col 0, PE1 col 1; 1 = PE0 col 2, PE1 col 3
rd_fb_o  out  1  operands taken from PE outputs this cycle instead of the matrix file
rd_swap_o  out  1  feedback operands row-reversed (x0 gets x1 output and vice versa)
step_o  out  3  index of step issued this cycle (valid when pe*_valid_o != 0)
wb_valid_o  out  1  PE outputs are valid this cycle; top level writes them to the file
wb_row_o  out  1  destination row pair
wb_col_o  out  1  destination column pair
wb_swap_o  out  1  PE x0 output goes to the higher row of the pair

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, counters 0, tag pipeline cleared. All outputs 0.
- Step table, fixed. Fields: scheme0/scheme1, row, col, fb, swap.
  - S0: 0/1, r0 c0, fb0 sw0
  - S1: 1/1, r0 c1, fb0 sw0
  - S2: 0/1, r1 c0, fb0 sw0
  - S3: 1/1, r1 c1, fb0 sw0
  - S4: 2/3, r0 c0, fb1 sw0
  - S5: 3/3, r0 c1, fb1 sw0
  - S6: 2/3, r1 c0, fb1 sw1
  - S7: 3/3, r1 c1, fb1 sw1
- States:
  - IDLE: start_i=1 moves to ISSUE_A. start_i is ignored in all other states.
  - ISSUE_A: issue S0..S3 on consecutive cycles, then go to WAIT_A.
  - WAIT_A: count until the S0 result emerges, then go to ISSUE_B.
  - ISSUE_B: issue S4..S7 on consecutive cycles, then go to DRAIN.
  - DRAIN: wait until the last writeback, then go to DONE.
  - DONE: one cycle, done_o=1, then return to IDLE.
- Timing. Cycle 1 is the first cycle after start_i is sampled; L = PE_LAT.
  - S0..S3 issue in cycles 1..4.
  - S4..S7 issue in cycles 1+L..4+L. Each Sk+4 issues in the same cycle that the Sk writeback emerges, because feedback operands are the live PE outputs.
  - S0..S3 writebacks are in cycles 1+L..4+L; S4..S7 writebacks are in cycles 1+2L..4+2L.
  - done_o is high in cycle 5+2L. busy_o is high in cycles 1..4+2L.
  - When L=4 there are no WAIT_A cycles: ISSUE_A is followed directly by ISSUE_B.
- Tag pipeline: shift register of depth L holding {valid, step}. wb_* fields decode from the step field of the tag at the output stage.
- Outputs are registered state decodes. All issue and wb fields are 0 in cycles without an issue or writeback.
- S6/S7 writebacks carry wb_swap_o=1.
- Reset mid-pass aborts immediately. No writeback is emitted after rst is released, and done_o is not pulsed.
- Back-to-back passes: a start_i in the cycle done_o is high is ignored. A start_i in the following IDLE cycle is accepted.

Decomposition:
- Shared package holds:
  - scheme localparams (COMPLEX_2_REAL=0, COMPLEX_ROTATE=1, REAL_NULLIFIED=2, RELATED_ROTATE=3)
  - state encodings
  - step-table field widths
  - PE_LAT default
- Sub-module pe_tag_pipe (parameter DEPTH, WIDTH): delay line for {valid, step} tags. The step table is a case-decode function used in both the issue path and the writeback path.

Test Plan:
- Reset, then start_i pulse, L=8:
  - pe0_valid_o=2'b11 in cycles 1-4, 9-12.
  - Schemes: cycle 1 is 0/1; cycle 9 is 2/3.
  - rd_fb_o=1 only in cycles 9-12.
  - done_o high in cycle 21 only; busy_o high in cycles 1-20.
- Writeback check, L=8: wb_valid_o in cycles 9-12 and 17-20. (row,col) sequence is 00,01,10,11 twice. wb_swap_o=1 in cycles 19-20 only.
- start_i held high for 30 cycles: exactly one pass. A second pass begins at cycle 23 (IDLE at cycle 22 re-samples start_i). No overlap of issue with the previous drain.
- rst asserted at cycle 10 mid-pass: all outputs 0 asynchronously. After release with no start_i: wb_valid_o stays 0 and done_o never pulses.
- PE_LAT=4: issue in cycles 1-8 contiguous, wb in cycles 5-12, done_o in cycle 13.
- PE_LAT=15: S4 issue and S0 writeback both in cycle 16; done_o in cycle 35.
